// File: rtl/dmux_dispatcher.sv
// rtl/dmux_dispatcher.sv - two-channel demultiplexing dispatcher with holding registers
//
// Purpose:
//   Accepts one word per cycle from a valid/ready source and loads it into one
//   of two single-entry output holding registers. The target channel is chosen
//   by in_sel (mode=0) or by an internal round-robin pointer (mode=1). Each
//   channel drains independently through its own valid/ready handshake and
//   keeps a modulo-256 count of the words it has accepted.
//
// Ports:
//   clk                    single clock, rising edge
//   rst_n                  synchronous active-low reset
//   enable                 1 = accept input, 0 = block input (outputs still drain)
//   mode                   0 = route by in_sel, 1 = round-robin
//   in_valid/in_sel/in_data  input word, target select and payload
//   in_ready               dispatcher can accept this cycle
//   out0_*/out1_*          per-channel holding register (valid, data, ready)
//   cnt0/cnt1              words accepted per channel, modulo 256
//   rr_ptr                 next round-robin target
module dmux_dispatcher #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic             rr_ptr
);

  logic             out0_valid_q, out0_valid_d;
  logic             out1_valid_q, out1_valid_d;
  logic [WIDTH-1:0] out0_data_q,  out0_data_d;
  logic [WIDTH-1:0] out1_data_q,  out1_data_d;
  logic [7:0]       cnt0_q,       cnt0_d;
  logic [7:0]       cnt1_q,       cnt1_d;
  logic             rr_ptr_q,     rr_ptr_d;

  logic tgt;
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic load0;
  logic load1;

  // Target is purely combinational from the current inputs and pointer state.
  assign tgt       = mode ? rr_ptr_q : in_sel;
  assign tgt_valid = tgt ? out1_valid_q : out0_valid_q;
  assign tgt_ready = tgt ? out1_ready   : out0_ready;

  // A full target can still take a word when its consumer drains it in the
  // same cycle. rst_n gates readiness so nothing looks acceptable during reset.
  assign in_ready = rst_n & enable & (~tgt_valid | tgt_ready);
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~tgt;
  assign load1    = accept &  tgt;

  always_comb begin
    out0_valid_d = out0_valid_q;
    out1_valid_d = out1_valid_q;
    out0_data_d  = out0_data_q;
    out1_data_d  = out1_data_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    rr_ptr_d     = rr_ptr_q;

    // Load wins over drain, so a simultaneous drain+load keeps valid high.
    if (load0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
      cnt0_d       = cnt0_q + 8'd1;
    end else if (out0_valid_q && out0_ready) begin
      out0_valid_d = 1'b0;
    end

    if (load1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
      cnt1_d       = cnt1_q + 8'd1;
    end else if (out1_valid_q && out1_ready) begin
      out1_valid_d = 1'b0;
    end

    // Pointer only advances on round-robin accepts; mode changes leave it alone.
    if (accept && mode) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      cnt0_q       <= 8'd0;
      cnt1_q       <= 8'd0;
      rr_ptr_q     <= 1'b0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign rr_ptr     = rr_ptr_q;

endmodule

// File: doc/dmux_dispatcher.md
DMUX_DISPATCHER -- requirements
Module: dmux_dispatcher

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  1 = accept input; 0 = in_ready forced 0, outputs keep draining.
REQ-005 mode  input  1  0 = route by in_sel; 1 = round-robin.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_sel  input  1  target channel in mode 0 (0 -> ch0, 1 -> ch1).
REQ-008 in_data  input  WIDTH  input word.
REQ-009 in_ready  output  1  dispatcher can accept this cycle.
REQ-010 out0_valid, out1_valid  output  1 each  channel holding register full.
REQ-011 out0_data, out1_data  output  WIDTH each  channel holding register contents.
REQ-012 out0_ready, out1_ready  input  1 each  channel consumer takes word.
REQ-013 cnt0, cnt1  output  8 each  words accepted per channel.
REQ-014 rr_ptr  output  1  next round-robin target.

Function
REQ-015 Target t SHALL be in_sel when mode=0 and rr_ptr when mode=1, combinational from current inputs and state.
REQ-016 in_ready SHALL equal enable AND (NOT outt_valid OR outt_ready), combinational; no dependence on in_valid.
REQ-017 Accept SHALL occur when in_valid AND in_ready at a rising edge; only accepts change counters, pointer or channel t loading.
REQ-018 On accept: outt_data <= in_data, outt_valid <= 1; latency 1 cycle from accept to valid.
REQ-019 Drain: outX_valid AND outX_ready with no load to X in the same cycle SHALL clear outX_valid next cycle; outX_data SHALL hold its last value.
REQ-020 Simultaneous drain and load of the same channel SHALL keep outX_valid=1 and replace data; full throughput of 1 word/cycle per channel.
REQ-021 Non-target channel SHALL be unaffected by an accept; both channels SHALL drain independently in the same cycle.
REQ-022 outX_valid SHALL stay 1 with stable data until taken (no drop, no overwrite while full and not ready).
REQ-023 rr_ptr SHALL toggle on each accept while mode=1; SHALL hold in mode=0 and when no accept occurs; mode changes SHALL not alter rr_ptr.
REQ-024 cntX SHALL increment by 1 on each accept to channel X, modulo 256 (255 -> 0).
REQ-025 in_valid with in_ready=0 SHALL have no effect; source holds word until accepted.
REQ-026 enable falling SHALL block new accepts the same cycle; already held words SHALL remain and drain normally.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0, rr_ptr=0.
REQ-028 in_ready SHALL be 0 while rst_n=0.
REQ-029 Reset mid-operation SHALL discard held words with no output handshake; an accept coinciding with reset SHALL be lost.

Verification
REQ-030 mode=0, outs ready=1, send 0x11 sel0, 0x22 sel1 back-to-back -> out0 0x11 cycle+1, out1 0x22 cycle+2; cnt0=1, cnt1=1.
REQ-031 mode=1, outs ready=1, send 0xA0,0xA1,0xA2,0xA3 -> ch0 gets 0xA0,0xA2; ch1 gets 0xA1,0xA3; rr_ptr ends 0.
REQ-032 mode=0, out0_ready=0, send 0x55 then 0x66 to ch0 -> 0x55 held, in_ready=0 until out0_ready=1; 0x66 loads same cycle 0x55 drains.
REQ-033 256 accepts to ch1 with ready=1 -> cnt1 wraps to 0, cnt0 stays 0.
REQ-034 both channels full, assert rst_n=0 one cycle -> all valids 0, data 0, counters 0, rr_ptr 0; no extra output handshake.
REQ-035 enable=0 with in_valid=1 for 5 cycles -> in_ready=0, counters unchanged; held words still drain.
